conv3x3_stream: RTL
===================

Name: conv3x3_stream

Overview:
Streaming 3x3 convolution engine, the parametrised successor of the fixed 28x28 ROM-addressed convolver. It accepts raster-order pixels over a valid/ready stream and buffers two image rows internally. It emits "valid"-region results, (IMG_W-2)x(IMG_H-2) per frame, over a valid/ready stream. Kernel coefficients are runtime-loadable, with optional ReLU. It sits between the image source (ROM reader or camera front-end) and the pooling/activation stages of the CNN datapath.

Parameters:
IMG_W, 28, pixels per row (>=3)
IMG_H, 28, rows per frame (>=3)
PIX_W, 8, unsigned pixel width
COEF_W, 8, signed two's-complement coefficient width
ACC_W, PIX_W+COEF_W+5, signed output width (derived; never overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  engine can accept pixel
s_data  in  PIX_W  unsigned pixel, raster order
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  ACC_W  signed convolution result
m_last  out  1  high with final result of a frame
coef_we  in  1  coefficient write strobe
coef_idx  in  4  coefficient index 0..8 (row-major: 0 top-left, 8 bottom-right)
coef_data  in  COEF_W  signed coefficient value
relu_en  in  1  clamp negative results to 0
frame_done  out  1  one-cycle pulse after last input pixel of a frame is accepted

Behaviour:
- Reset (async, rst=1): m_valid=0, m_data=0, m_last=0, frame_done=0, col=row=0.
- Reset loads coefficients with the vertical edge filter {1,0,-1, 1,0,-1, 1,0,-1}.
- Line-buffer contents are don't-care after reset; they are never read before being rewritten in a new frame.
- Handshake: input accepted when s_valid&&s_ready. Output transferred when m_valid&&m_ready.
- s_ready = !m_valid || m_ready (single output register; full throughput, no combinational path s_valid->s_ready).
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted pixels.
- col wraps to 0 and row increments at IMG_W-1. After (IMG_W-1, IMG_H-1) both wrap to 0: next pixel starts a new frame. No idle cycles are required between frames.
- Window: 3x3 register array fed by the incoming pixel and two line buffers of depth IMG_W (rows r-1, r-2).
- On accepting pixel at (row,col) with row>=2 and col>=2:
  - m_data <= sum over i,j of k[3i+j] * p[row-2+i][col-2+j], where the bottom-right term is the incoming pixel.
  - m_valid <= 1 on the next edge; latency is 1 cycle from acceptance.
- Positions with row<2 or col<2 produce no output.
- If that accept coincides with the current output transferring, the register reloads with m_valid staying 1.
- If m_valid=1 and m_ready=0, m_data and m_last hold stable; s_ready=0.
- If m_valid=1, m_ready=1 and no new result is loaded, m_valid <= 0.
- Arithmetic:
  - Each pixel is zero-extended to PIX_W+1 bits signed before the multiply. Product width is PIX_W+COEF_W+1.
  - The nine-term sum is sign-extended to ACC_W; no overflow is possible.
  - If relu_en=1 when the result is registered and the sum is negative, m_data <= 0. relu_en is sampled per result.
- m_last=1 with the result produced by pixel (IMG_W-1, IMG_H-1).
- frame_done pulses on the edge after that pixel is accepted; otherwise 0.
- Coefficient write: when coef_we=1, k[coef_idx] <= coef_data on the edge. The new value is used for results registered from the following cycle on.
  - Writes are allowed mid-frame; no shadowing.
  - coef_idx>8 is ignored.
  - A write and a computing accept in the same cycle: the computation uses the old value.
- Reset mid-frame: counters return to 0 and any pending output is dropped. The next accepted pixel is (0,0) of a new frame.

Decomposition:
- Shared package conv_pkg holds:
  - default kernel constant (edge filter above);
  - coefficient-index constants;
  - function for derived ACC_W.
- One natural sub-module, line_buffer: depth IMG_W, width PIX_W, single-port shift/circular RAM advancing on accept enable. Instantiated twice (cascaded).
- MAC tree and counters stay in conv3x3_stream.

Test Plan:
- 4x4 frame (IMG_W=IMG_H=4), pixels 1..16, default kernel, m_ready=1 -> exactly 4 outputs, each -6; m_last on 4th only; frame_done one pulse.
- Same frame, relu_en=1 -> 4 outputs of 0.
- Write all k=1 via coef_we, same frame -> outputs 54, 63, 90, 99.
- All pixels 255, all k=-128 -> every output -293760, no wrap; with relu_en=1 -> 0.
- Random m_ready stalls on back-to-back frames (pixels 1..16 then 17..32) -> ordering preserved, m_data stable while stalled, s_ready low while stalled; second frame all -6.
- rst asserted after 7 pixels, then full frame 1..16 -> m_valid=0 immediately, then 4 outputs of -6 as in first test.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and helpers for the streaming 3x3 convolver.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int C_NUM_COEF         = 9;
    localparam int C_COEF_IDX_W       = 4;
    localparam int C_IDX_TOP_LEFT     = 0;
    localparam int C_IDX_CENTER       = 4;
    localparam int C_IDX_BOTTOM_RIGHT = 8;

    // Vertical edge filter {1,0,-1} per row; 2-bit signed fields, index 0 at LSB.
    localparam logic [2*C_NUM_COEF-1:0] C_DEFAULT_KERNEL = {
        2'b11, 2'b00, 2'b01,
        2'b11, 2'b00, 2'b01,
        2'b11, 2'b00, 2'b01
    };

    function automatic int default_coef(input int idx);
        logic signed [1:0] v;
        v = C_DEFAULT_KERNEL[idx*2 +: 2];
        return int'(v);
    endfunction

    // Nine products of (PIX_W+1)x(COEF_W) signed need 4 extra bits of growth.
    function automatic int acc_width(input int pix_w, input int coef_w);
        return pix_w + coef_w + 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One-row circular delay line; output is the sample written
//               DEPTH enables ago, replaced by the new sample on enable.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == C_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Contents need no reset: every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_stream
// Description : Streaming 3x3 valid-region convolution with runtime kernel
//               and optional ReLU over valid/ready streams.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [PIX_W-1:0]                           s_data,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic signed [acc_width(PIX_W, COEF_W)-1:0] m_data,
    output logic                                       m_last,
    input  logic                                       coef_we,
    input  logic [C_COEF_IDX_W-1:0]                    coef_idx,
    input  logic signed [COEF_W-1:0]                   coef_data,
    input  logic                                       relu_en,
    output logic                                       frame_done
);

    localparam int ACC_W  = acc_width(PIX_W, COEF_W);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] C_COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] C_ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic signed [COEF_W-1:0] r_coef [C_NUM_COEF];
    logic [PIX_W-1:0]         r_win  [3][2];
    logic [PIX_W-1:0]         w_lb1_q;
    logic [PIX_W-1:0]         w_lb2_q;
    logic [PIX_W-1:0]         w_col  [3];
    logic [PIX_W-1:0]         w_pix  [C_NUM_COEF];
    logic signed [PROD_W-1:0] w_prod [C_NUM_COEF];
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_result;
    logic                     w_accept;
    logic                     w_compute;
    logic                     w_last_pos;

    assign s_ready    = !m_valid || m_ready;
    assign w_accept   = s_valid && s_ready;
    assign w_last_pos = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
    assign w_compute  = w_accept && (r_col >= C_COL_FIRST) && (r_row >= C_ROW_FIRST);

    // lb1 yields the row above the incoming pixel, lb2 the row above that.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_accept),
        .i_din  (s_data),
        .o_dout (w_lb1_q)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_accept),
        .i_din  (w_lb1_q),
        .o_dout (w_lb2_q)
    );

    // Rightmost window column is combinational so the result lands 1 cycle after accept.
    always_comb begin
        w_col[0] = w_lb2_q;
        w_col[1] = w_lb1_q;
        w_col[2] = s_data;
        for (int i = 0; i < 3; i++) begin
            w_pix[3*i]     = r_win[i][0];
            w_pix[3*i + 1] = r_win[i][1];
            w_pix[3*i + 2] = w_col[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= w_col[i];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int t = 0; t < C_NUM_COEF; t++) begin
            w_prod[t] = PROD_W'($signed({1'b0, w_pix[t]})) * PROD_W'(r_coef[t]);
            w_sum     = w_sum + ACC_W'(w_prod[t]);
        end
    end

    assign w_result = (relu_en && w_sum[ACC_W-1]) ? '0 : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_COEF; i++) begin
                r_coef[i] <= COEF_W'(default_coef(i));
            end
        end else begin
            for (int i = 0; i < C_NUM_COEF; i++) begin
                if (coef_we && (coef_idx == C_COEF_IDX_W'(i))) begin
                    r_coef[i] <= coef_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == C_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_accept && w_last_pos;
            if (w_compute) begin
                m_valid <= 1'b1;
                m_data  <= w_result;
                m_last  <= w_last_pos;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
